// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared frame layout constants, FSM state type and byte helper
//            for the AES SPI frame path.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int FRAME_BYTES = 42;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;

  localparam int OPC_OFS   = 0;
  localparam int KEY_OFS   = 1;
  localparam int BLK_OFS   = 17;
  localparam int NONCE_OFS = 33;
  localparam int CSUM_OFS  = 41;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PRESENT = 2'd2
  } frame_state_t;

  // Byte idx of an MSB-first frame (byte 0 in the top bits).
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame,
                                            input logic [5:0]            idx);
    logic [FRAME_BITS-1:0] w_shift;
    w_shift = frame << {idx, 3'b000};
    return w_shift[FRAME_BITS-1 -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Multi-stage synchronizer with registered rising-edge detect.
//            Flops reset high so a level already asserted at reset release
//            does not produce an edge.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/aes_frame_unpack.sv
`default_nettype none
// ============================================================================
// Module   : aes_frame_unpack
// Brief    : Captures a 42-byte SPI frame into the clk domain, optionally
//            verifies its XOR checksum (macro AES_FRAME_CHECKSUM_EN) and
//            presents opcode/key/block/nonce over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module aes_frame_unpack #(
  parameter int FRAME_BYTES = 42,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] spi_data,
  input  logic                     spi_valid,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               opcode,
  output logic [127:0]             key,
  output logic [127:0]             block,
  output logic [63:0]              nonce,
  output logic                     frame_err,
  output logic                     overrun
);

  import aes_pkg::*;

  localparam int c_top = 8*FRAME_BYTES - 1;

  frame_state_t             r_state;
  frame_state_t             w_next_state;
  logic [8*FRAME_BYTES-1:0] r_shadow;
  logic                     r_overrun;
  logic                     r_ovr_pend;
  logic                     w_overrun;
  logic                     w_ovr_pend;
  logic                     w_load;
  logic                     w_rise;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_valid),
    .rise     (w_rise)
  );

`ifdef AES_FRAME_CHECKSUM_EN
  localparam logic [5:0] c_last_idx = 6'(CSUM_OFS - 1);

  logic [7:0] r_acc;
  logic [7:0] w_acc_nx;
  logic [5:0] r_idx;
  logic [5:0] w_idx_nx;
  logic       r_frame_err;
  logic       w_frame_err;
  logic [7:0] w_byte;
  logic [7:0] w_csum;

  assign w_byte = frame_byte(r_shadow, r_idx);
  assign w_csum = frame_byte(r_shadow, 6'(CSUM_OFS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_acc       <= w_acc_nx;
      r_idx       <= w_idx_nx;
      r_frame_err <= w_frame_err;
    end
  end

  assign frame_err = r_frame_err;
`else
  logic w_unused_csum;
  assign w_unused_csum = ^r_shadow[7:0];
  assign frame_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_overrun  <= 1'b0;
      r_ovr_pend <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_overrun  <= w_overrun;
      r_ovr_pend <= w_ovr_pend;
      if (w_load) begin
        r_shadow <= spi_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_overrun    = r_ovr_pend;
    w_ovr_pend   = 1'b0;
`ifdef AES_FRAME_CHECKSUM_EN
    w_acc_nx     = r_acc;
    w_idx_nx     = r_idx;
    w_frame_err  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_load = 1'b1;
`ifdef AES_FRAME_CHECKSUM_EN
          w_next_state = CHECK;
          w_acc_nx     = '0;
          w_idx_nx     = '0;
`else
          w_next_state = PRESENT;
`endif
        end
      end
`ifdef AES_FRAME_CHECKSUM_EN
      CHECK: begin
        // idx stops at the last data byte; the final compare folds it in.
        if (r_idx == c_last_idx) begin
          if ((r_acc ^ w_byte) == w_csum) begin
            w_next_state = PRESENT;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = IDLE;
          end
        end else begin
          w_acc_nx = r_acc ^ w_byte;
          w_idx_nx = r_idx + 6'd1;
        end
      end
`endif
      PRESENT: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    // An overrun landing on the cycle out_valid rises is reported one cycle late.
    if (w_rise && (r_state != IDLE)) begin
      if ((w_next_state == PRESENT) && (r_state != PRESENT)) begin
        w_ovr_pend = 1'b1;
      end else begin
        w_overrun = 1'b1;
      end
    end
  end

  assign out_valid = (r_state == PRESENT);
  assign overrun   = r_overrun;
  assign opcode    = r_shadow[c_top - 8*OPC_OFS   -: 8];
  assign key       = r_shadow[c_top - 8*KEY_OFS   -: 128];
  assign block     = r_shadow[c_top - 8*BLK_OFS   -: 128];
  assign nonce     = r_shadow[c_top - 8*NONCE_OFS -: 64];

endmodule
`default_nettype wire

// File: doc/aes_frame_unpack.md
Name: aes_frame_unpack

Overview:
- Downstream consumer of the 42-byte SPI frame receiver.
- Moves the receiver's `spi_valid` into the `clk` domain and snapshots the 336-bit frame.
- Optionally verifies an XOR checksum, then presents opcode, key, plaintext block and nonce to the AES core over a valid/ready handshake.
- Frame layout, MSB-first: byte0 = `data[335:328]` opcode; bytes1-16 key; bytes17-32 block; bytes33-40 nonce; byte41 checksum.

Parameters:
- `FRAME_BYTES`, 42: bytes per frame. The frame layout is fixed, so only 42 is supported.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_valid`. Must be 2 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- spi_data  in  336  frame from the SPI receiver (sck domain)
- spi_valid  in  1  frame-complete flag from the SPI receiver (sck domain)
- out_ready  in  1  AES core accepts the frame
- out_valid  out  1  frame fields valid
- opcode  out  8  byte0
- key  out  128  bytes1-16; byte1 in `[127:120]`
- block  out  128  bytes17-32; byte17 in `[127:120]`
- nonce  out  64  bytes33-40; byte33 in `[63:56]`
- frame_err  out  1  one-cycle pulse: checksum mismatch, frame dropped
- overrun  out  1  one-cycle pulse: new frame arrived while busy, new frame dropped

Behaviour:
- Reset, asynchronous: state = IDLE; shadow register, accumulator and index cleared; all outputs 0.
  - Synchronizer and edge flops reset to 1, so a `spi_valid` already high at reset release is ignored. The frame is taken only after a low→high transition.
- `rise` = synchronized `spi_valid` high AND previous-cycle value low.
- Source contract: `spi_data` stays stable from `spi_valid` rising until at least `SYNC_STAGES`+2 `clk` cycles later. The host keeps sck idle for that long.
- States:
  - IDLE: on `rise`, capture `spi_data` into the 336-bit shadow, clear accumulator, set idx = 0, go to CHECK. When `CHECKSUM_EN` is undefined, go to PRESENT instead.
  - CHECK: each cycle acc ^= shadow byte[idx], idx++. Bytes 0..40 are consumed in 41 cycles. After byte 40:
    - if acc == byte41, go to PRESENT;
    - else pulse `frame_err`, go to IDLE.
  - PRESENT: `out_valid` = 1; fields are driven combinationally from the shadow and held stable. When `out_valid` and `out_ready` are both high on a clock edge, drop `out_valid` and go to IDLE. `out_valid` never drops without a handshake.
- Latency: edge 1 is the first `clk` edge sampling `spi_valid` high. With `SYNC_STAGES`=2, `out_valid` rises after edge 45 with checksum, or after edge 4 without. `out_ready` held high gives a 1-cycle PRESENT.
- `rise` in CHECK or PRESENT: shadow is untouched, frame dropped, `overrun` pulses one cycle, and the current state continues.
- `rise` in the same cycle the handshake completes is also an overrun. The block returns to IDLE.
- idx is 6 bits and saturates at 40; it is never used beyond 41.
- Reset mid-CHECK or mid-PRESENT aborts immediately: `out_valid` = 0, and no `frame_err` or `overrun` pulse.
- `frame_err` and `overrun` never assert in the same cycle as `out_valid` rising.

Optional Feature:
- Macro: `AES_FRAME_CHECKSUM_EN`.
- Defined: CHECK state present; byte41 must equal the XOR of bytes 0..40; `frame_err` is live.
- Undefined: CHECK state, accumulator and idx are compiled out; byte41 is ignored; `frame_err` is tied to 0; IDLE goes directly to PRESENT.

Decomposition:
- Shared package `aes_pkg`:
  - `FRAME_BYTES`, `FRAME_BITS` (336);
  - byte offsets `OPC_OFS`=0, `KEY_OFS`=1, `BLK_OFS`=17, `NONCE_OFS`=33, `CSUM_OFS`=41;
  - enum `frame_state_t {IDLE, CHECK, PRESENT}`.
- Sub-module `sync_edge`: `SYNC_STAGES`-deep synchronizer plus rising-edge detect, with reset value 1. Reusable for other sck-domain flags.

Test Plan:
- Good frame: opcode 0x01, key 000102..0F, block 00112233..FF, nonce 0xA5 ×8, correct checksum; `out_ready`=1 → `out_valid` for exactly 1 cycle after edge 45, all fields match, `frame_err`=0.
- Bad checksum: same frame with byte41 ^ 0x01 → `frame_err` pulses once at edge 45, `out_valid` never rises, state IDLE.
- Backpressure: `out_ready`=0 for 20 cycles, then 1 → `out_valid` and fields held constant for all 20 cycles; handshake on the first ready cycle, `out_valid`=0 next cycle.
- Overrun: second `spi_valid` rise with new data while in PRESENT with `out_ready`=0 → `overrun` pulses 1 cycle, fields keep first-frame values; after the handshake, no spurious second `out_valid`.
- Reset: assert `reset` mid-CHECK with `spi_valid` held high, then release → all outputs 0, no frame output until `spi_valid` goes low then high. The subsequent good frame is presented normally.
- Build without `AES_FRAME_CHECKSUM_EN`: corrupted byte41 → frame still presented after edge 4, `frame_err` stays 0.
